// File: rtl/definitions.sv
// Shared BeeF memory-path types: operation codes, source/address selectors
// and the loader state encoding.
package definitions;

    typedef logic [7:0] BYTE;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_WRITE = 2'd1,
        MEM_READ  = 2'd2
    } MEM_OP;

    typedef enum logic [1:0] {
        MEM_FROM_CU     = 2'd0,
        MEM_FROM_ALU    = 2'd1,
        MEM_FROM_LOADER = 2'd2
    } MEM_SRC;

    typedef enum logic [1:0] {
        ADDR_FROM_PC     = 2'd0,
        ADDR_FROM_CU     = 2'd1,
        ADDR_FROM_LOADER = 2'd2
    } MEM_ADDR;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WRITE  = 3'd2,
        S_VERIFY = 3'd3,
        S_DRAIN  = 3'd4,
        S_FINISH = 3'd5
    } loader_state_t;

endpackage

// File: rtl/mem_loader_read_valid_pipe.sv
// Tracks outstanding read-back requests: one bit per cycle of memory read
// latency, with the oldest request appearing on valid_out.
module read_valid_pipe #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    output logic valid_out,
    output logic empty
);

    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] pipe_d;

    // Shift new requests in at stage 0, oldest request exits at the top stage.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = push;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipe state, cleared asynchronously so in-flight reads are forgotten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_out = pipe_q[READ_LATENCY-1];
    assign empty     = (pipe_q == '0);

endmodule

// File: rtl/mem_loader.sv
// Streams bytes into consecutive memory addresses while the arbiter grants
// the port, then optionally reads the region back and compares checksums.
module mem_loader
    import definitions::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              verify_en,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output MEM_OP             mem_op,
    output MEM_SRC            mem_src,
    output MEM_ADDR           mem_addr,
    output logic [ADDR_W-1:0] loader_addr,
    output logic [7:0]        loader_out,
    input  logic [7:0]        mem_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        checksum
);

    loader_state_t     state_q,   state_d;
    logic [ADDR_W-1:0] base_q,    base_d;
    logic [ADDR_W:0]   len_q,     len_d;
    logic [ADDR_W:0]   count_q,   count_d;
    logic              verify_q,  verify_d;
    MEM_OP             mem_op_q,  mem_op_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [7:0]        out_q,     out_d;
    logic [7:0]        csum_q,    csum_d;
    logic [7:0]        rsum_q,    rsum_d;
    logic              error_q,   error_d;
    logic              done_q,    done_d;
    logic              busy_q,    busy_d;
    logic              bus_req_q, bus_req_d;

    logic pipe_push;
    logic pipe_out;
    logic pipe_empty;

    read_valid_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_valid_pipe (
        .clk      (clk),
        .reset    (reset),
        .push     (pipe_push),
        .valid_out(pipe_out),
        .empty    (pipe_empty)
    );

    assign in_ready = (state_q == S_WRITE) && bus_gnt && (count_q < len_q);

    // Next-state and datapath updates for the loader sequence.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        count_d   = count_q;
        verify_d  = verify_q;
        mem_op_d  = MEM_NOP;
        addr_d    = addr_q;
        out_d     = out_q;
        csum_d    = csum_q;
        rsum_d    = rsum_q;
        error_d   = error_q;
        pipe_push = 1'b0;

        // Read-back data arrives independently of the issuing state.
        if (pipe_out) begin
            rsum_d = rsum_q + mem_out;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base;
                    len_d    = len;
                    verify_d = verify_en;
                    count_d  = '0;
                    csum_d   = '0;
                    rsum_d   = '0;
                    error_d  = 1'b0;
                    state_d  = (len == '0) ? S_FINISH : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (count_q == len_q) begin
                    if (verify_q) begin
                        count_d = '0;
                        state_d = S_VERIFY;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else if (in_valid && in_ready) begin
                    mem_op_d = MEM_WRITE;
                    out_d    = in_data;
                    addr_d   = base_q + count_q[ADDR_W-1:0];
                    csum_d   = csum_q + in_data;
                    count_d  = count_q + (ADDR_W+1)'(1);
                end
            end
            S_VERIFY: begin
                if (count_q == len_q) begin
                    state_d = S_DRAIN;
                end else if (bus_gnt) begin
                    mem_op_d  = MEM_READ;
                    addr_d    = base_q + count_q[ADDR_W-1:0];
                    count_d   = count_q + (ADDR_W+1)'(1);
                    pipe_push = 1'b1;
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                error_d = verify_q && (rsum_q != csum_q);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the upcoming state.
        done_d    = (state_d == S_FINISH);
        busy_d    = (state_d != S_IDLE);
        bus_req_d = (state_d == S_REQ) || (state_d == S_WRITE) ||
                    (state_d == S_VERIFY) || (state_d == S_DRAIN);
    end

    // Loader state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            verify_q  <= 1'b0;
            mem_op_q  <= MEM_NOP;
            addr_q    <= '0;
            out_q     <= '0;
            csum_q    <= '0;
            rsum_q    <= '0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            count_q   <= count_d;
            verify_q  <= verify_d;
            mem_op_q  <= mem_op_d;
            addr_q    <= addr_d;
            out_q     <= out_d;
            csum_q    <= csum_d;
            rsum_q    <= rsum_d;
            error_q   <= error_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            bus_req_q <= bus_req_d;
        end
    end

    assign mem_op      = mem_op_q;
    assign mem_src     = MEM_FROM_LOADER;
    assign mem_addr    = ADDR_FROM_LOADER;
    assign loader_addr = addr_q;
    assign loader_out  = out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign checksum    = csum_q;
    assign bus_req     = bus_req_q;

endmodule

// File: doc/mem_loader.md
# mem_loader

Program/data loader for the BeeF processor memory. It accepts a byte stream over a valid/ready handshake and writes the bytes into consecutive memory addresses through `mem_unit`, acting as the initiator on the `MEM_FROM_LOADER` data path. It can optionally read the region back through `mem_out` and compare an 8-bit checksum. It sits beside the control unit and owns the memory port only while the bus arbiter grants it.

## Interface
- `ADDR_W`, 8: memory address width.
- `READ_LATENCY`, 1: cycles from a registered `mem_op == MEM_READ` to valid `mem_out`, range 1–4.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse. Latches `base`, `len` and `verify_en`; ignored unless IDLE.
- `base`  in  ADDR_W  first write address.
- `len`  in  ADDR_W+1  byte count, 0..2^ADDR_W.
- `verify_en`  in  1  enable the read-back checksum phase.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  BYTE  stream byte.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `bus_req`  out  1  request for the memory port.
- `bus_gnt`  in  1  grant from the arbiter.
- `mem_op`  out  MEM_OP  registered; `MEM_NOP`, `MEM_WRITE` or `MEM_READ`.
- `mem_src`  out  MEM_SRC  constant `MEM_FROM_LOADER`.
- `mem_addr`  out  MEM_ADDR  constant `ADDR_FROM_LOADER`.
- `loader_addr`  out  ADDR_W  registered access address.
- `loader_out`  out  BYTE  registered write data.
- `mem_out`  in  BYTE  read data from `mem_unit`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at completion.
- `error`  out  1  checksum mismatch. Sticky; cleared by an accepted `start`.
- `checksum`  out  BYTE  mod-256 sum of the written bytes, valid once `done` has pulsed.

## Operation
**States:** IDLE, REQ, WRITE, VERIFY, DRAIN, FINISH.

- **IDLE**
  - On `start` with `len == 0`: go to FINISH. `bus_req` never rises.
  - On `start` with `len > 0`: go to REQ.
  - On either: clear `error`, `checksum`, the read-back sum and `count`.
- **REQ**
  - `bus_req = 1`.
  - Go to WRITE on the first edge where `bus_gnt == 1`.
- **WRITE**
  - `in_ready = (state == WRITE) && bus_gnt && count < len`. This is combinational.
  - On handshake (`in_valid && in_ready`), at the next edge:
    - `mem_op <= MEM_WRITE`
    - `loader_out <= in_data`
    - `loader_addr <= base + count`
    - `checksum += in_data`
    - `count++`
  - On cycles with no handshake, `mem_op <= MEM_NOP`.
  - When `count == len`: go to VERIFY if `verify_en` is set, otherwise go to FINISH. Reset `count` on the way to VERIFY.
- **VERIFY**
  - Each cycle with `bus_gnt` and `count < len`:
    - `mem_op <= MEM_READ`
    - `loader_addr <= base + count`
    - `count++`
    - Push 1 into the `READ_LATENCY`-deep valid pipe.
  - When all reads have been issued: go to DRAIN.
- **DRAIN**
  - `mem_op = MEM_NOP`.
  - Wait until the valid pipe is empty, then go to FINISH.
- **Read-back capture** (VERIFY and DRAIN)
  - When the pipe output is 1, `rsum += mem_out`.
- **FINISH**
  - Pulse `done` for one cycle.
  - `error <= verify_en && (rsum != checksum)`.
  - Drop `bus_req` and return to IDLE.
- **Address arithmetic:** `base + count` wraps mod 2^ADDR_W, so `base = 0xFE` gives 0xFE, 0xFF, 0x00.
- **Grant loss** (`bus_gnt` low in WRITE or VERIFY):
  - `in_ready = 0`, `mem_op <= MEM_NOP`, no new reads are issued.
  - `bus_req` stays high.
  - Reads already in flight are still captured.
- **`start` while busy:** ignored.

## Timing
- **Reset values** (asynchronous, applied immediately, including mid-operation):
  - State IDLE.
  - `mem_op = MEM_NOP`; `loader_addr`, `loader_out`, `checksum` = 0.
  - `in_ready`, `bus_req`, `busy`, `done`, `error` = 0.
  - The valid pipe is cleared.
- **Write latency:** a handshake at edge N puts `MEM_WRITE` on `mem_op` from edge N to N+1.
- **Throughput:** one byte per cycle with `in_valid` and `bus_gnt` held high.
- **Start to bus request:** `start` sampled at edge 0 gives `bus_req = 1` after edge 0. `in_ready` can be high in the cycle after the grant is sampled.
- **Verify timing:** a `MEM_READ` registered at edge N has its `mem_out` sampled at edge N + `READ_LATENCY`.
- **`done`:** rises the cycle after the last write (no verify) or after the last read-back sample (verify).

## Structure
Add the following to the `definitions` package:
- `MEM_NOP` in `MEM_OP`, if it is not already present.
- `MEM_FROM_LOADER` in `MEM_SRC`.
- `ADDR_FROM_LOADER` in `MEM_ADDR`.
- `loader_state_t` enum holding the six states.

One sub-module, `read_valid_pipe`: a parameterised `READ_LATENCY`-deep shift register with an `empty` flag. Everything else stays in `mem_loader`.

## Test plan
- **Basic write:** `base = 0x10`, `len = 4`, bytes A0 A1 A2 A3, `bus_gnt` tied high, no verify.
  - Writes of A0..A3 to 0x10..0x13 on consecutive cycles.
  - `checksum = 0x86`, one `done` pulse, `error = 0`.
- **Address wrap:** `base = 0xFE`, `len = 3`.
  - `loader_addr` sequence 0xFE, 0xFF, 0x00.
- **Verify, pass and fail:** `verify_en = 1`, memory model with latency 1.
  - Correct read-back data: `error = 0`.
  - One read-back byte corrupted by +1: `error = 1`, held until the next `start`.
- **Stalls:** `in_valid` gaps plus `bus_gnt` low for 3 cycles mid-write.
  - No `MEM_WRITE` and `in_ready = 0` during the stalls.
  - Byte order and addresses unchanged.
- **Zero length:** `len = 0`.
  - `done` on the cycle after `start`.
  - `bus_req` and `mem_op` never leave 0 / `MEM_NOP`.
- **Reset mid-operation:** `reset` low after 2 of 5 bytes.
  - All outputs return to reset values immediately.
  - A following `start` completes normally.
